// File: rtl/eth_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_framer_pkg
//   Shared Ethernet TX/RX constants. The framer uses them, and so do the
//   Manchester serializer and the receiver, so the values below stay in one
//   place.
//   Contents:
//     ETH_PREAMBLE_BYTE / ETH_SFD_BYTE : start-of-frame delimiter bytes
//     ETH_CRC32_POLY / ETH_CRC32_INIT  : reflected IEEE 802.3 CRC-32
//     ETH_LEN_W                        : width of the data length counter
//     eth_state_e                      : framer state encoding
//     eth_fcs_byte()                   : selects one FCS byte, LSB byte first
// -----------------------------------------------------------------------------
package eth_tx_framer_pkg;

    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC32_INIT    = 32'hFFFFFFFF;

    // An 11-bit length counter saturates at 2047, above any legal frame.
    localparam int unsigned ETH_LEN_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } eth_state_e;

    // The FCS is the complemented CRC register. The line sends it least
    // significant byte first, so byte idx 0 is fcs[7:0].
    function automatic logic [7:0] eth_fcs_byte(input logic [31:0] crc,
                                                input logic [1:0]  idx);
        logic [31:0] fcs_sh;
        fcs_sh = (~crc) >> {idx, 3'b000};
        return fcs_sh[7:0];
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// -----------------------------------------------------------------------------
// eth_crc32_byte
//   Combinational next-state for the reflected IEEE 802.3 CRC-32. It takes one
//   byte per call and processes its bits LSB first, with eight shift/xor steps
//   unrolled. The TX framer uses it, and the RX checker will reuse it.
//   Ports:
//     crc_in  [31:0] : current CRC register
//     data    [7:0]  : byte to absorb
//     crc_out [31:0] : CRC register after absorbing data
// -----------------------------------------------------------------------------
module eth_crc32_byte
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ ETH_CRC32_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// -----------------------------------------------------------------------------
// eth_tx_framer
//   Byte-stream framer placed ahead of the 10BASE-T Manchester serializer.
//   It takes a raw MAC frame (dst, src, type, payload) and sends out, in order:
//   the preamble, the SFD, the data bytes, zero padding up to MIN_DATA_LEN, and
//   a hardware-computed CRC-32 FCS. After that it holds an inter-frame gap
//   before it accepts the next frame.
//   Ports:
//     eth_clk, eth_rstn          : clock, asynchronous active-low reset
//     s_valid/s_data/s_last      : input frame bytes from the MAC
//     s_ready                    : input byte accepted (only while in DATA)
//     m_valid/m_data/m_last      : framed bytes to the serializer
//     m_ready                    : serializer takes the byte
//     busy                       : framer is not idle
//     frame_done / frame_err     : one-cycle pulses after the last FCS byte;
//                                  frame_err means the data exceeded
//                                  MAX_DATA_LEN
// -----------------------------------------------------------------------------
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_DATA_LEN = 60,
    parameter int MAX_DATA_LEN = 1514,
    parameter int IFG_CYCLES   = 192
) (
    input  logic       eth_clk,
    input  logic       eth_rstn,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int unsigned CNT_W = 16;

    localparam logic [ETH_LEN_W-1:0] LEN_SAT  = '1;
    localparam logic [ETH_LEN_W-1:0] MIN_LEN  = ETH_LEN_W'(MIN_DATA_LEN);
    localparam logic [ETH_LEN_W-1:0] MAX_LEN  = ETH_LEN_W'(MAX_DATA_LEN);
    localparam logic [CNT_W-1:0]     PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    // The IDLE cycle that follows IFG also drives m_valid low. IFG therefore
    // lasts one cycle less than the gap, so the line is quiet for exactly
    // IFG_CYCLES cycles before the next preamble.
    localparam logic [CNT_W-1:0]     IFG_LAST = CNT_W'(IFG_CYCLES - 2);

    eth_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ETH_LEN_W-1:0]   len_q;
    logic [31:0]            crc_q;
    logic                   oversize_q;
    logic                   tx_valid_q;
    logic [7:0]             tx_data_q;
    logic                   tx_last_q;
    logic                   done_q;
    logic                   err_q;

    logic                   in_data;
    logic                   xfer;
    logic [7:0]             crc_byte;
    logic [31:0]            crc_d;
    logic [ETH_LEN_W-1:0]   len_d;

    // DATA is a combinational pass-through, so the producer's valid and data
    // reach the serializer with no added latency. Every other state drives
    // the registered byte.
    assign in_data    = (state_q == ST_DATA);
    assign m_valid    = in_data ? s_valid : tx_valid_q;
    assign m_data     = in_data ? s_data  : tx_data_q;
    assign m_last     = tx_last_q;
    assign s_ready    = in_data & m_ready;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;

    assign xfer       = m_valid & m_ready;

    // Pad bytes are zero and also count toward the CRC.
    assign crc_byte   = in_data ? s_data : 8'h00;
    assign len_d      = (len_q == LEN_SAT) ? len_q : len_q + ETH_LEN_W'(1);

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_d)
    );

    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            crc_q      <= ETH_CRC32_INIT;
            oversize_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // The waiting byte is not consumed here. It is taken in
                    // DATA, after the preamble and SFD.
                    if (s_valid) begin
                        state_q    <= ST_PREAMBLE;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ETH_PREAMBLE_BYTE;
                        tx_last_q  <= 1'b0;
                        cnt_q      <= '0;
                    end
                end

                ST_PREAMBLE: begin
                    if (xfer) begin
                        if (cnt_q == PRE_LAST) begin
                            state_q   <= ST_SFD;
                            tx_data_q <= ETH_SFD_BYTE;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_SFD: begin
                    if (xfer) begin
                        state_q    <= ST_DATA;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= 8'h00;
                        crc_q      <= ETH_CRC32_INIT;
                        len_q      <= '0;
                        oversize_q <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        crc_q <= crc_d;
                        len_q <= len_d;
                        // An oversize frame still passes unmodified. It is
                        // only flagged at frame_done.
                        if (len_d > MAX_LEN) begin
                            oversize_q <= 1'b1;
                        end
                        if (s_last) begin
                            tx_valid_q <= 1'b1;
                            if (len_d < MIN_LEN) begin
                                state_q   <= ST_PAD;
                                tx_data_q <= 8'h00;
                            end else begin
                                state_q   <= ST_FCS;
                                tx_data_q <= eth_fcs_byte(crc_d, 2'd0);
                                cnt_q     <= '0;
                            end
                        end
                    end
                end

                ST_PAD: begin
                    if (xfer) begin
                        crc_q <= crc_d;
                        len_q <= len_d;
                        if (len_d == MIN_LEN) begin
                            state_q   <= ST_FCS;
                            tx_data_q <= eth_fcs_byte(crc_d, 2'd0);
                            cnt_q     <= '0;
                        end
                    end
                end

                ST_FCS: begin
                    if (xfer) begin
                        if (cnt_q[1:0] == 2'd3) begin
                            state_q    <= ST_IFG;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
                            tx_last_q  <= 1'b0;
                            done_q     <= 1'b1;
                            err_q      <= oversize_q;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q     <= cnt_q + CNT_W'(1);
                            tx_data_q <= eth_fcs_byte(crc_q, cnt_q[1:0] + 2'd1);
                            tx_last_q <= (cnt_q[1:0] == 2'd2);
                        end
                    end
                end

                ST_IFG: begin
                    if (cnt_q == IFG_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
module tb_eth_tx_framer;

    localparam int PRE_N = 7;
    localparam int MIN_N = 60;
    localparam int MAX_N = 1514;
    localparam int IFG_N = 192;

    logic clk = 1'b0;
    logic eth_rstn;
    always #5 clk = ~clk;

    // main DUT (default parameters)
    logic       s_valid, s_last, s_ready;
    logic [7:0] s_data;
    logic       m_valid, m_last, m_ready;
    logic [7:0] m_data;
    logic       busy, frame_done, frame_err;

    // known-answer DUT (MIN_DATA_LEN = 9)
    logic       k_s_valid, k_s_last, k_s_ready;
    logic [7:0] k_s_data;
    logic       k_m_valid, k_m_last;
    logic       k_m_ready;
    logic [7:0] k_m_data;
    logic       k_busy, k_done, k_err;

    eth_tx_framer #(
        .PREAMBLE_LEN(PRE_N), .MIN_DATA_LEN(MIN_N),
        .MAX_DATA_LEN(MAX_N), .IFG_CYCLES(IFG_N)
    ) u_dut (
        .eth_clk(clk), .eth_rstn(eth_rstn),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    eth_tx_framer #(
        .PREAMBLE_LEN(7), .MIN_DATA_LEN(9),
        .MAX_DATA_LEN(1514), .IFG_CYCLES(192)
    ) u_kat (
        .eth_clk(clk), .eth_rstn(eth_rstn),
        .s_valid(k_s_valid), .s_data(k_s_data), .s_last(k_s_last), .s_ready(k_s_ready),
        .m_valid(k_m_valid), .m_data(k_m_data), .m_last(k_m_last), .m_ready(k_m_ready),
        .busy(k_busy), .frame_done(k_done), .frame_err(k_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed { logic [7:0] d; logic last; } ob_t;
    ob_t  exp_q[$];
    logic exp_err_q[$];
    int   exp_len_q[$];

    function automatic logic [31:0] fcs_ref(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic expect_frame(input logic [7:0] data[$]);
        logic [7:0]  body[$];
        logic [31:0] fcs;
        ob_t         e;
        body = data;
        while (body.size() < MIN_N) body.push_back(8'h00);
        fcs = fcs_ref(body);
        for (int i = 0; i < PRE_N; i++) begin e.d = 8'h55; e.last = 1'b0; exp_q.push_back(e); end
        e.d = 8'hD5; e.last = 1'b0; exp_q.push_back(e);
        foreach (body[i]) begin e.d = body[i]; e.last = 1'b0; exp_q.push_back(e); end
        for (int k = 0; k < 4; k++) begin
            e.d = fcs[8*k +: 8]; e.last = (k == 3); exp_q.push_back(e);
        end
        exp_err_q.push_back(data.size() > MAX_N);
        exp_len_q.push_back(PRE_N + 1 + body.size() + 4);
    endtask

    // ---------------- m_ready generator ----------------
    int rdy_mode = 0;   // 0: always, 1: one cycle in 16, 2: random
    initial begin
        int cyc;
        cyc = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (rdy_mode)
                1:       m_ready = ((cyc % 16) == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
        end
    end

    // ---------------- producer ----------------
    bit gap_en = 1'b0;

    task automatic push_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        @(negedge clk);
        while (!s_ready && t < 4000) begin @(negedge clk); t++; end
        if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        foreach (b[i]) push_byte(b[i], i == b.size() - 1);
    endtask

    task automatic gen_frame(input int n, output logic [7:0] b[$]);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_err_q.size() != 0) && t < budget) begin
            @(posedge clk); t++;
        end
        #1;
        chk("scoreboard_drain", 32'(exp_q.size() + exp_err_q.size()), 0);
    endtask

    // ---------------- monitor (main DUT) ----------------
    initial begin
        ob_t        e;
        bit         prev_stall, in_gap, gap_sv, done_due;
        logic [7:0] prev_data;
        logic       prev_last;
        int         gap, xfer_cnt;
        prev_stall = 0; in_gap = 0; gap_sv = 0; done_due = 0;
        prev_data = 8'h00; prev_last = 1'b0; gap = 0; xfer_cnt = 0;
        forever begin
            @(negedge clk);
            if (!eth_rstn) begin
                prev_stall = 0; in_gap = 0; done_due = 0; xfer_cnt = 0;
            end else begin
                if (done_due) begin
                    done_due = 0;
                    chk("frame_done_pulse", 32'(frame_done), 1);
                    chk("exp_err_available", 32'(exp_err_q.size() > 0), 1);
                    if (exp_err_q.size() > 0) chk("frame_err", 32'(frame_err), 32'(exp_err_q.pop_front()));
                end else begin
                    chk("done_err_spurious", {30'h0, frame_done, frame_err}, 0);
                end

                if (prev_stall) begin
                    chk("hold_valid", 32'(m_valid), 1);
                    chk("hold_data", 32'(m_data), 32'(prev_data));
                    chk("hold_last", 32'(m_last), 32'(prev_last));
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;

                if (s_ready) chk("s_ready_without_m_ready", 32'(m_ready), 1);

                if (in_gap) begin
                    if (m_valid) begin
                        in_gap = 0;
                        if (gap_sv) chk("ifg_exact", 32'(gap), 32'(IFG_N));
                        else        chk("ifg_min", 32'(gap >= IFG_N), 1);
                    end else begin
                        gap++;
                        if (!s_valid) gap_sv = 0;
                    end
                end

                if (m_valid && m_ready) begin
                    xfer_cnt++;
                    chk("byte_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("m_data", 32'(m_data), 32'(e.d));
                        chk("m_last", 32'(m_last), 32'(e.last));
                    end
                    if (m_last) begin
                        done_due = 1; in_gap = 1; gap = 0; gap_sv = 1;
                        if (exp_len_q.size() > 0) chk("frame_transfers", 32'(xfer_cnt), 32'(exp_len_q.pop_front()));
                        xfer_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- collector (known-answer DUT) ----------------
    logic [8:0] k_got[$];
    int k_done_n = 0;
    int k_err_n  = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (eth_rstn) begin
                if (k_m_valid && k_m_ready) k_got.push_back({k_m_data, k_m_last});
                if (k_done) k_done_n++;
                if (k_err)  k_err_n++;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] f1[$];
        logic [7:0] f2[$];
        logic [7:0] s2[14];
        logic [7:0] kat_exp[21];
        int         t;
        int         blens[4];

        s2      = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
        kat_exp = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                    8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB};
        blens   = '{1, 59, 60, 61};

        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
        k_s_valid = 1'b0; k_s_data = 8'h00; k_s_last = 1'b0; k_m_ready = 1'b1;
        eth_rstn = 1'b0;

        // reset state (input held valid to show nothing is taken)
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        s_valid = 1'b0;
        eth_rstn = 1'b1;
        @(posedge clk); #1;

        // known answer, MIN_DATA_LEN=9: "123456789"
        for (int i = 0; i < 9; i++) begin
            int tk;
            tk = 0;
            k_s_valid = 1'b1; k_s_data = 8'h31 + 8'(i); k_s_last = (i == 8);
            @(negedge clk);
            if (i == 0) begin
                chk("kat_idle_no_output", 32'(k_m_valid), 0);
                @(negedge clk);
                chk("kat_preamble_latency", 32'(k_m_valid), 1);
            end
            while (!k_s_ready && tk < 200) begin @(negedge clk); tk++; end
            if (!k_s_ready) chk("kat_s_ready_timeout", 32'(k_s_ready), 1);
            @(posedge clk); #1;
        end
        k_s_valid = 1'b0; k_s_last = 1'b0;
        t = 0;
        while (k_done_n == 0 && t < 100) begin @(posedge clk); t++; end
        #1;
        chk("kat_done", 32'(k_done_n), 1);
        chk("kat_err", 32'(k_err_n), 0);
        chk("kat_busy_in_ifg", 32'(k_busy), 1);
        chk("kat_len", 32'(k_got.size()), 21);
        for (int i = 0; i < 21; i++)
            if (i < k_got.size()) chk("kat_byte", 32'(k_got[i]), 32'({kat_exp[i], 1'(i == 20)}));

        // 14-byte frame, padded to 60
        rdy_mode = 0;
        f1 = {};
        foreach (s2[i]) f1.push_back(s2[i]);
        expect_frame(f1);
        send_frame(f1);
        wait_drain(5000);

        // "123456789" at serializer rate (1-in-16 m_ready)
        rdy_mode = 1;
        f1 = {};
        for (int i = 0; i < 9; i++) f1.push_back(8'h31 + 8'(i));
        expect_frame(f1);
        send_frame(f1);
        wait_drain(5000);

        // back-to-back: second frame held valid through the gap
        rdy_mode = 2;
        gen_frame($urandom_range(20, 80), f1);
        gen_frame($urandom_range(1, 40), f2);
        expect_frame(f1);
        expect_frame(f2);
        send_frame(f1);
        send_frame(f2);
        wait_drain(5000);

        // reset after the fifth data byte, then restart
        rdy_mode = 0;
        gen_frame(20, f1);
        expect_frame(f1);
        for (int i = 0; i < 5; i++) push_byte(f1[i], 1'b0);
        eth_rstn = 1'b0;
        exp_q.delete(); exp_err_q.delete(); exp_len_q.delete();
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_s_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        eth_rstn = 1'b1;
        f1 = {};
        for (int i = 0; i < 9; i++) f1.push_back(8'h31 + 8'(i));
        expect_frame(f1);
        send_frame(f1);
        wait_drain(5000);

        // pad boundaries and random frames with producer gaps
        gap_en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            rdy_mode = (j % 2 == 0) ? 2 : 0;
            gen_frame((j < 4) ? blens[j] : int'($urandom_range(1, 130)), f1);
            expect_frame(f1);
            send_frame(f1);
            wait_drain(5000);
        end

        // oversize boundary: 1514 is legal, 1520 raises frame_err
        gap_en = 1'b0;
        rdy_mode = 0;
        gen_frame(1514, f1);
        expect_frame(f1);
        send_frame(f1);
        wait_drain(5000);
        gen_frame(1520, f1);
        expect_frame(f1);
        send_frame(f1);
        wait_drain(5000);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
